// File: rtl/sram_fifo_ctl_if.sv
// Signal bundle between sram_fifo_ctl and its neighbours: user write stream,
// user read stream, SRAM controller user port and status flags.
interface sram_fifo_ctl_if;
  // Valid/ready streams: a word moves on a rising edge where valid and ready
  // are both high; the source holds data stable while valid is high and
  // ready is low, and valid never waits on ready.
  logic [15:0] WR_DATA;
  logic        WR_VALID;
  logic        WR_READY;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic        RD_READY;
  logic [22:0] SRAM_ADDR_WR;
  logic [15:0] SRAM_DATA_IN;
  logic        SRAM_WE;
  logic [22:0] SRAM_ADDR_RD;
  logic        SRAM_RD;
  logic [15:0] SRAM_DATA_OUT;
  logic        SRAM_DATA_OUT_VALID;
  logic        FULL;
  logic        EMPTY;
  logic [23:0] USED;
  logic        ERROR;

  modport master (
    input  WR_DATA, WR_VALID, RD_READY, SRAM_DATA_OUT, SRAM_DATA_OUT_VALID,
    output WR_READY, RD_DATA, RD_VALID, SRAM_ADDR_WR, SRAM_DATA_IN, SRAM_WE,
           SRAM_ADDR_RD, SRAM_RD, FULL, EMPTY, USED, ERROR
  );

  modport slave (
    output WR_DATA, WR_VALID, RD_READY, SRAM_DATA_OUT, SRAM_DATA_OUT_VALID,
    input  WR_READY, RD_DATA, RD_VALID, SRAM_ADDR_WR, SRAM_DATA_IN, SRAM_WE,
           SRAM_ADDR_RD, SRAM_RD, FULL, EMPTY, USED, ERROR
  );
endinterface

// File: rtl/sram_fifo_ctl.sv
// Circular-buffer manager using an external ZBT SRAM as a deep 16-bit FIFO,
// with a credit-limited read path into a small first-word-fall-through FIFO.
module sram_fifo_ctl #(
  parameter logic [22:0] MAX_ADDR     = 23'h7FFFFF,
  parameter int          WRITE_LAT    = 3,
  parameter int          OUT_DEPTH    = 8,
  parameter int          FLUSH_CYCLES = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  sram_fifo_ctl_if.master bus
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  localparam logic [23:0]   CAP         = {1'b0, MAX_ADDR} + 24'd1;
  localparam logic [CW-1:0] CREDIT_INIT = CW'(OUT_DEPTH);
  localparam logic [FW-1:0] FLUSH_INIT  = FW'(FLUSH_CYCLES);

  logic [22:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [23:0]          used_q, used_d, committed_q, committed_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic [FW-1:0]        flush_q, flush_d;
  logic [WRITE_LAT-1:0] sh_q, sh_d;
  logic [PW-1:0]        ow_q, ow_d, or_q, or_d;
  logic [15:0]          mem_q [OUT_DEPTH];
  logic                 wr_ready_q, wr_ready_d, full_q, full_d;
  logic                 empty_q, empty_d, error_q, error_d;
  logic                 we_q, rd_q;
  logic [22:0]          addr_wr_q, addr_rd_q;
  logic [15:0]          data_in_q;
  logic                 accept, commit, issue, pop, ret, ofull, push, rd_valid;

  function automatic logic [22:0] wrap_inc(input logic [22:0] p);
    return (p == MAX_ADDR) ? 23'd0 : p + 23'd1;
  endfunction

  always_comb begin
    rd_valid = (ow_q != or_q);
    ofull    = (ow_q[AW] != or_q[AW]) && (ow_q[AW-1:0] == or_q[AW-1:0]);
    accept   = bus.WR_VALID && wr_ready_q;
    commit   = sh_q[WRITE_LAT-1];
    // A read may only be issued when a slot in the output FIFO is reserved.
    issue    = (committed_q != '0) && (credit_q != '0);
    pop      = rd_valid && bus.RD_READY;
    ret      = bus.SRAM_DATA_OUT_VALID && (flush_q == '0);
    push     = ret && !ofull;

    wr_ptr_d    = accept ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = issue ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    used_d      = used_q + 24'(accept) - 24'(issue);
    committed_d = committed_q + 24'(commit) - 24'(issue);
    credit_d    = credit_q + CW'(pop) - CW'(issue);
    sh_d        = WRITE_LAT'({sh_q, accept});
    flush_d     = (flush_q == '0) ? '0 : flush_q - FW'(1);
    ow_d        = ow_q + PW'(push);
    or_d        = or_q + PW'(pop);
    error_d     = error_q || (ret && ofull);
    wr_ready_d  = (used_d < CAP);
    full_d      = (used_d == CAP);
    empty_d     = (used_d == '0) && (ow_d == or_d);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      committed_q <= '0;
      credit_q    <= CREDIT_INIT;
      flush_q     <= FLUSH_INIT;
      sh_q        <= '0;
      ow_q        <= '0;
      or_q        <= '0;
      wr_ready_q  <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      error_q     <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_wr_q   <= '0;
      addr_rd_q   <= '0;
      data_in_q   <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      used_q      <= used_d;
      committed_q <= committed_d;
      credit_q    <= credit_d;
      flush_q     <= flush_d;
      sh_q        <= sh_d;
      ow_q        <= ow_d;
      or_q        <= or_d;
      wr_ready_q  <= wr_ready_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      error_q     <= error_d;
      we_q        <= accept;
      rd_q        <= issue;
      if (accept) begin
        addr_wr_q <= wr_ptr_q;
        data_in_q <= bus.WR_DATA;
      end
      if (issue) addr_rd_q <= rd_ptr_q;
      if (push) mem_q[ow_q[AW-1:0]] <= bus.SRAM_DATA_OUT;
    end
  end

  assign bus.WR_READY     = wr_ready_q;
  assign bus.RD_VALID     = rd_valid;
  assign bus.RD_DATA      = mem_q[or_q[AW-1:0]];
  assign bus.SRAM_WE      = we_q;
  assign bus.SRAM_ADDR_WR = addr_wr_q;
  assign bus.SRAM_DATA_IN = data_in_q;
  assign bus.SRAM_RD      = rd_q;
  assign bus.SRAM_ADDR_RD = addr_rd_q;
  assign bus.FULL         = full_q;
  assign bus.EMPTY        = empty_q;
  assign bus.USED         = used_q;
  assign bus.ERROR        = error_q;

endmodule

// File: tb/tb_sram_fifo_ctl.sv
// Bench for sram_fifo_ctl with a 16-word SRAM (MAX_ADDR=15): SRAM model with
// two-cycle read return, expected-data queue and a decoupled output monitor.
module tb_sram_fifo_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_fifo_ctl_if bus ();

  sram_fifo_ctl #(.MAX_ADDR(23'd15)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  logic [15:0] mem [16];
  logic [22:0] exp_wa = '0;
  logic [22:0] exp_ra = '0;
  int we_cnt = 0, rd_cnt = 0, pop_cnt = 0;
  int we_cyc = -100, rd_cyc = -100, first_pop_cyc = -1, last_pop_cyc = -1;
  int inj_n = 0;
  logic [15:0] inj_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM controller model: read data valid two cycles after SRAM_RD, plus injection.
  initial begin
    logic p0, p1;
    logic [15:0] d0, d1;
    p0 = 1'b0; p1 = 1'b0; d0 = '0; d1 = '0;
    bus.SRAM_DATA_OUT_VALID = 1'b0;
    bus.SRAM_DATA_OUT       = '0;
    forever begin
      @(negedge clk);
      bus.SRAM_DATA_OUT_VALID = p1 || (inj_n > 0);
      bus.SRAM_DATA_OUT       = (inj_n > 0) ? inj_data : d1;
      if (inj_n > 0) inj_n--;
      p1 = p0;
      d1 = d0;
      p0 = bus.SRAM_RD;
      d0 = mem[bus.SRAM_ADDR_RD[3:0]];
      if (bus.SRAM_WE) mem[bus.SRAM_ADDR_WR[3:0]] = bus.SRAM_DATA_IN;
    end
  end

  // Monitor: address sequences and popped data against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.SRAM_WE) begin
        check("we_addr", bus.SRAM_ADDR_WR, exp_wa);
        exp_wa = (exp_wa == 23'd15) ? 23'd0 : exp_wa + 23'd1;
        we_cnt++;
        we_cyc = cyc;
      end
      if (bus.SRAM_RD) begin
        check("rd_addr", bus.SRAM_ADDR_RD, exp_ra);
        exp_ra = (exp_ra == 23'd15) ? 23'd0 : exp_ra + 23'd1;
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (bus.RD_VALID && bus.RD_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no word", bus.RD_DATA);
        end else begin
          check("rd_data", bus.RD_DATA, exp_q.pop_front());
        end
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic push_word(input logic [15:0] d);
    int guard = 0;
    bus.WR_DATA  = d;
    bus.WR_VALID = 1'b1;
    while (!bus.WR_READY && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus.WR_READY) exp_q.push_back(d);
    else check("push_timeout", 32'(guard), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int g = 0;
    while (exp_q.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before 300000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int t0, rv_cyc, acc, rd_base, we_base, g;
    logic [15:0] d;
    bus.WR_VALID = 1'b0;
    bus.WR_DATA  = '0;
    bus.RD_READY = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_wr_ready", bus.WR_READY, 0);
    check("rst_we", bus.SRAM_WE, 0);
    check("rst_rd", bus.SRAM_RD, 0);
    check("rst_rd_valid", bus.RD_VALID, 0);
    check("rst_full", bus.FULL, 0);
    check("rst_empty", bus.EMPTY, 1);
    check("rst_used", bus.USED, 0);
    check("rst_error", bus.ERROR, 0);
    check("rst_addr_wr", bus.SRAM_ADDR_WR, 0);
    check("rst_addr_rd", bus.SRAM_ADDR_RD, 0);
    check("rst_data_in", bus.SRAM_DATA_IN, 0);
    rst = 1'b0;
    @(negedge clk);
    check("wr_ready_after_reset", bus.WR_READY, 1);
    repeat (5) @(negedge clk);

    // Single word latency from an empty buffer.
    bus.RD_READY = 1'b1;
    bus.WR_DATA  = 16'hA5A5;
    bus.WR_VALID = 1'b1;
    exp_q.push_back(16'hA5A5);
    t0 = cyc;
    @(negedge clk);
    bus.WR_VALID = 1'b0;
    rv_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus.RD_VALID) begin
        rv_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t1_we_cycle", 32'(we_cyc - t0), 32'd1);
    check("t1_rd_cycle", 32'(rd_cyc - t0), 32'd5);
    check("t1_rd_valid_cycle", 32'(rv_cyc - t0), 32'd8);
    check("t1_empty_while_valid", bus.EMPTY, 0);
    @(negedge clk);
    check("t1_empty_after_pop", bus.EMPTY, 1);
    check("t1_rd_valid_after_pop", bus.RD_VALID, 0);

    // Sustained stream of 1000 words.
    pop_cnt = 0;
    first_pop_cyc = -1;
    for (int i = 0; i < 1000; i++) push_word(16'h1000 + 16'(i));
    bus.WR_VALID = 1'b0;
    wait_drain("t2_drain", 500);
    repeat (2) @(negedge clk);
    check("t2_pop_count", 32'(pop_cnt), 32'd1000);
    check("t2_no_gaps", 32'(last_pop_cyc - first_pop_cyc), 32'd999);
    check("t2_error", bus.ERROR, 0);
    check("t2_used", bus.USED, 0);
    check("t2_empty", bus.EMPTY, 1);

    // Fill to capacity with the reader stalled.
    bus.RD_READY = 1'b0;
    rd_base = rd_cnt;
    we_base = we_cnt;
    acc = 0;
    d = 16'h2000;
    for (int k = 0; k < 40; k++) begin
      bus.WR_DATA  = d;
      bus.WR_VALID = 1'b1;
      if (bus.WR_READY) begin
        exp_q.push_back(d);
        d = d + 16'd1;
        acc++;
      end
      @(negedge clk);
    end
    bus.WR_VALID = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_accepted", 32'(acc), 32'd24);
    check("t3_we_pulses", 32'(we_cnt - we_base), 32'd24);
    check("t3_rd_pulses", 32'(rd_cnt - rd_base), 32'd8);
    check("t3_full", bus.FULL, 1);
    check("t3_wr_ready", bus.WR_READY, 0);
    check("t3_used", bus.USED, 16);
    check("t3_rd_valid", bus.RD_VALID, 1);

    bus.RD_READY = 1'b1;
    @(negedge clk);
    bus.RD_READY = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_rd_after_pop", 32'(rd_cnt - rd_base), 32'd9);
    check("t3_used_after_pop", bus.USED, 15);
    check("t3_wr_ready_after_pop", bus.WR_READY, 1);

    // Return with the output FIFO full is dropped and flagged.
    inj_data = 16'hDEAD;
    inj_n = 1;
    repeat (3) @(negedge clk);
    check("t4_error_set", bus.ERROR, 1);
    check("t4_used", bus.USED, 15);
    bus.RD_READY = 1'b1;
    wait_drain("t4_drain", 200);
    repeat (3) @(negedge clk);
    check("t4_error_sticky", bus.ERROR, 1);
    check("t4_used_end", bus.USED, 0);
    check("t4_empty_end", bus.EMPTY, 1);
    check("t4_full_end", bus.FULL, 0);

    // Reset with three reads in flight, then flush window.
    rd_base = rd_cnt;
    push_word(16'h3001);
    push_word(16'h3002);
    push_word(16'h3003);
    bus.WR_VALID = 1'b0;
    g = 0;
    while (rd_cnt - rd_base < 3 && g < 30) begin
      @(negedge clk);
      #3;
      g++;
    end
    check("t5_three_in_flight", 32'(rd_cnt - rd_base), 32'd3);
    rst = 1'b1;
    inj_data = 16'hBEEF;
    inj_n = 4;
    exp_q.delete();
    exp_wa = '0;
    exp_ra = '0;
    #1;
    check("t5_rst_rd", bus.SRAM_RD, 0);
    check("t5_rst_wr_ready", bus.WR_READY, 0);
    check("t5_rst_used", bus.USED, 0);
    check("t5_rst_empty", bus.EMPTY, 1);
    check("t5_rst_error", bus.ERROR, 0);
    @(negedge clk);
    #3;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_rd_valid_after_flush", bus.RD_VALID, 0);
    check("t5_error_after_flush", bus.ERROR, 0);
    check("t5_used_after_flush", bus.USED, 0);
    check("t5_empty_after_flush", bus.EMPTY, 1);
    check("t5_wr_ready", bus.WR_READY, 1);
    bus.RD_READY = 1'b1;
    we_base = we_cnt;
    pop_cnt = 0;
    push_word(16'h1234);
    bus.WR_VALID = 1'b0;
    wait_drain("t5_drain", 50);
    repeat (2) @(negedge clk);
    check("t5_one_write", 32'(we_cnt - we_base), 32'd1);
    check("t5_one_pop", 32'(pop_cnt), 32'd1);
    check("t5_empty_end", bus.EMPTY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctl.md
# sram_fifo_ctl

Circular-buffer manager that turns the external ZBT SRAM into a deep 16-bit stream FIFO. It is the initiator on the user side of the SRAM controller: it accepts a valid/ready write stream and issues write strobes and addresses. It then issues read strobes, collects returned data into a small output FIFO and presents it as a valid/ready read stream. Sits between the event/data path and the readout interface in the stream_fifo subsystem.

## Interface
- MAX_ADDR, 23'h7FFFFF: last SRAM word address used; capacity CAP = MAX_ADDR+1 words.
- WRITE_LAT, 3: cycles after an SRAM_WE pulse before that address may be read.
- OUT_DEPTH, 8: output FIFO depth in words, power of two, 4..32.
- FLUSH_CYCLES, 4: cycles after reset release during which SRAM_DATA_OUT_VALID is ignored.

- CLK  in  1  single clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high.
- WR_DATA  in  16  write stream data.
- WR_VALID  in  1  write stream valid.
- WR_READY  out  1  write stream ready, registered.
- RD_DATA  out  16  read stream data.
- RD_VALID  out  1  read stream valid.
- RD_READY  in  1  read stream ready.
- SRAM_ADDR_WR  out  23  write address to controller.
- SRAM_DATA_IN  out  16  write data to controller.
- SRAM_WE  out  1  one-cycle write strobe.
- SRAM_ADDR_RD  out  23  read address to controller.
- SRAM_RD  out  1  one-cycle read strobe.
- SRAM_DATA_OUT  in  16  read data from controller.
- SRAM_DATA_OUT_VALID  in  1  read data valid.
- FULL  out  1  used == CAP.
- EMPTY  out  1  used == 0 and output FIFO empty.
- USED  out  24  words written to SRAM but not yet read-issued.
- ERROR  out  1  sticky: read data arrived with output FIFO full.

## Operation
- State: wr_ptr and rd_ptr (23 b), used (24 b, includes pending writes), committed (24 b, readable words), credit (0..OUT_DEPTH), flush counter.
- Write: accept when WR_VALID & WR_READY. Next cycle: SRAM_WE=1, SRAM_ADDR_WR=wr_ptr, SRAM_DATA_IN=WR_DATA. wr_ptr increments; it wraps MAX_ADDR -> 0. used increments.
- WR_READY is registered as next_used < CAP. It deasserts in the same cycle FULL rises, so no write is ever accepted at full.
- Commit: each SRAM_WE pulse increments committed WRITE_LAT cycles later, via a WRITE_LAT-deep shift of WE.
- Read issue: when committed > 0 and credit > 0, assert SRAM_RD for one cycle with SRAM_ADDR_RD=rd_ptr. Then: rd_ptr++ (wraps like wr_ptr), used--, committed--, credit--. At most one read per cycle.
- Credit returns +1 on each RD_VALID & RD_READY pop. In-flight reads plus output FIFO occupancy never exceed OUT_DEPTH.
- Return: SRAM_DATA_OUT_VALID pushes SRAM_DATA_OUT into the output FIFO. If the FIFO is full, the word is dropped and ERROR sets.
- Output FIFO is first-word-fall-through; RD_DATA is stable while RD_VALID & ~RD_READY.
- Simultaneous accept, commit, read issue and pop in one cycle: all counters apply net deltas (e.g. used +1-1 = unchanged).
- Reset (async): pointers, used, committed, output FIFO and shift registers clear; credit=OUT_DEPTH. SRAM_WE, SRAM_RD, RD_VALID, WR_READY, FULL, ERROR = 0; EMPTY=1; USED=0; address/data outputs 0. The flush counter loads FLUSH_CYCLES.
- Reset mid-operation: all buffered data is discarded. SRAM_DATA_OUT_VALID is ignored while RESET is high and for FLUSH_CYCLES cycles after release; no ERROR is raised in that window.

## Timing
- WR_READY first asserts in the first cycle after RESET deasserts.
- Write accepted in cycle 0: SRAM_WE in cycle 1, committed visible in cycle 1+WRITE_LAT, SRAM_RD earliest in cycle 2+WRITE_LAT (cycle 5 at default).
- The controller returns data 2 cycles after SRAM_RD. RD_VALID follows SRAM_DATA_OUT_VALID by 1 cycle. Empty-buffer write-to-RD_VALID is therefore cycle 8 at defaults.
- Sustained throughput: 1 word/cycle each direction. Write and read strobes may be active in the same cycle.
- FULL, EMPTY and USED are registered and reflect state after the current edge's updates.

## Test plan
- Single word 0xA5A5 written to an empty FIFO after reset -> SRAM_WE cycle 1 with addr 0; SRAM_RD cycle 5 with addr 0; RD_VALID with 0xA5A5 in cycle 8; EMPTY returns to 1 after the pop.
- Continuous write of 1000 incrementing words with RD_READY=1 -> read data in identical order, no gaps after fill, ERROR=0, USED ends at 0.
- MAX_ADDR=15, RD_READY=0 -> exactly 16 words reach SRAM plus OUT_DEPTH are read; FULL=1, WR_READY=0 with no further WE. Raising RD_READY drains all words in order, with addresses wrapping 15 -> 0.
- RD_READY held low with 20 words stored, OUT_DEPTH=8 -> exactly 8 SRAM_RD pulses, then none until a pop. Each pop yields one more SRAM_RD.
- Injected SRAM_DATA_OUT_VALID with the output FIFO full -> word dropped, ERROR=1 and stays set until reset.
- RESET pulsed with 3 reads in flight -> all outputs at reset values, returning valids ignored for 4 cycles, USED=0. The next written word 0x1234 is read back from addr 0.
